// File: rtl/bms_pkg.sv
// Shared battery-management types: charger FSM states, charge-rate and fault-code encodings.
package bms_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FAST   = 3'd1,
        ST_TOPOFF = 3'd2,
        ST_FULL   = 3'd3,
        ST_FAULT  = 3'd4
    } chg_state_e;

    typedef enum logic [1:0] {
        RATE_OFF    = 2'b00,
        RATE_TOPOFF = 2'b01,
        RATE_FAST   = 2'b10
    } chg_rate_e;

    typedef enum logic [1:0] {
        FC_NONE       = 2'b00,
        FC_OVERCHARGE = 2'b01,
        FC_TIMEOUT    = 2'b10
    } fault_code_e;

    function automatic chg_rate_e rate_for(input chg_state_e s);
        case (s)
            ST_FAST:   return RATE_FAST;
            ST_TOPOFF: return RATE_TOPOFF;
            default:   return RATE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/charge_safety_timer.sv
// Per-phase safety timer: restarts on phase entry, counts while enabled, flags when the
// cycle about to complete is the limit-th cycle of the phase.
module charge_safety_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        enable,
    input  logic [15:0] limit,
    output logic        expired
);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds completed cycles; the current cycle is number count_q+1
    assign expired = enable && (({1'b0, count_q} + 17'd1) >= {1'b0, limit});

endmodule

// File: rtl/charge_controller.sv
// Battery charge controller FSM (IDLE/FAST/TOPOFF/FULL/FAULT) with registered outputs.
// Optional safety timeout enabled by defining CHARGE_TIMEOUT_EN.
module charge_controller
    import bms_pkg::*;
#(
    parameter logic [15:0] FAST_TIMEOUT   = 16'd50000,
    parameter logic [15:0] TOPOFF_TIMEOUT = 16'd10000,
    parameter logic [7:0]  FAULT_HOLD     = 8'd100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       charger_present,
    input  logic       pulse_20,
    input  logic       pulse_80,
    input  logic       pulse_100,
    input  logic       clk_enable,
    input  logic       overcharge_alert,
    input  logic       fault_clear,
    output logic       charge_en,
    output logic [1:0] charge_rate,
    output logic [2:0] state,
    output logic       charge_done,
    output logic       low_batt_warn,
    output logic       fault,
    output logic [1:0] fault_code
);

    chg_state_e  state_q, state_d;
    fault_code_e cause_d, fault_code_q;
    chg_rate_e   charge_rate_q;
    logic        charge_en_q, charge_done_q, fault_q, warn_q, warn_d;
    logic [7:0]  hold_q;
    logic        in_charge, fast_entry, expired_w;

    assign in_charge  = (state_q == ST_FAST) || (state_q == ST_TOPOFF);
    assign fast_entry = (state_d == ST_FAST) && (state_q != ST_FAST);

`ifdef CHARGE_TIMEOUT_EN
    logic        timer_restart;
    logic [15:0] timer_limit;

    assign timer_restart = ((state_d == ST_FAST) || (state_d == ST_TOPOFF)) && (state_d != state_q);
    assign timer_limit   = (state_q == ST_FAST) ? FAST_TIMEOUT : TOPOFF_TIMEOUT;

    charge_safety_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (timer_restart),
        .enable  (in_charge),
        .limit   (timer_limit),
        .expired (expired_w)
    );
`else
    // Timeout limits are inert in this build; referenced only so both builds share one interface
    assign expired_w = 1'b0 & (|{FAST_TIMEOUT, TOPOFF_TIMEOUT});
`endif

    always_comb begin
        state_d = state_q;
        cause_d = FC_NONE;
        case (state_q)
            ST_IDLE: begin
                if (charger_present && clk_enable && !overcharge_alert) state_d = ST_FAST;
            end
            ST_FAST, ST_TOPOFF, ST_FULL: begin
                if (overcharge_alert) begin
                    state_d = ST_FAULT;
                    cause_d = FC_OVERCHARGE;
                end else if (!charger_present) begin
                    state_d = ST_IDLE;
                end else if (expired_w) begin
                    state_d = ST_FAULT;
                    cause_d = FC_TIMEOUT;
                end else if (state_q == ST_FAST) begin
                    if (pulse_100)     state_d = ST_FULL;
                    else if (pulse_80) state_d = ST_TOPOFF;
                end else if (state_q == ST_TOPOFF) begin
                    if (pulse_100 || !clk_enable) state_d = ST_FULL;
                end else begin
                    if (clk_enable) state_d = ST_TOPOFF;
                end
            end
            ST_FAULT: begin
                if (fault_clear && !overcharge_alert && (hold_q == FAULT_HOLD)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        warn_d = warn_q;
        if (pulse_20)                   warn_d = 1'b1;
        else if (pulse_80 || fast_entry) warn_d = 1'b0;
    end

    // Outputs are decoded from state_d so they match the state entered at this edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            charge_en_q   <= 1'b0;
            charge_rate_q <= RATE_OFF;
            charge_done_q <= 1'b0;
            warn_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= FC_NONE;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            charge_en_q   <= (state_d == ST_FAST) || (state_d == ST_TOPOFF);
            charge_rate_q <= rate_for(state_d);
            charge_done_q <= (state_d == ST_FULL);
            fault_q       <= (state_d == ST_FAULT);
            warn_q        <= warn_d;
            if (state_d != ST_FAULT)      fault_code_q <= FC_NONE;
            else if (state_q != ST_FAULT) fault_code_q <= cause_d;
            if (state_q != ST_FAULT)      hold_q <= '0;
            else if (hold_q != FAULT_HOLD) hold_q <= hold_q + 8'd1;
        end
    end

    assign state         = state_q;
    assign charge_en     = charge_en_q;
    assign charge_rate   = charge_rate_q;
    assign charge_done   = charge_done_q;
    assign low_batt_warn = warn_q;
    assign fault         = fault_q;
    assign fault_code    = fault_code_q;

endmodule

// File: tb/tb_charge_controller.sv
// Directed, table-driven bench for charge_controller; expectations adapt to CHARGE_TIMEOUT_EN.
module tb_charge_controller;

    logic       clk = 1'b0;
    logic       reset, charger_present, pulse_20, pulse_80, pulse_100;
    logic       clk_enable, overcharge_alert, fault_clear;
    logic       charge_en, charge_done, low_batt_warn, fault;
    logic [1:0] charge_rate, fault_code;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    charge_controller #(
        .FAST_TIMEOUT   (16'd20),
        .TOPOFF_TIMEOUT (16'd30),
        .FAULT_HOLD     (8'd100)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .charger_present  (charger_present),
        .pulse_20         (pulse_20),
        .pulse_80         (pulse_80),
        .pulse_100        (pulse_100),
        .clk_enable       (clk_enable),
        .overcharge_alert (overcharge_alert),
        .fault_clear      (fault_clear),
        .charge_en        (charge_en),
        .charge_rate      (charge_rate),
        .state            (state),
        .charge_done      (charge_done),
        .low_batt_warn    (low_batt_warn),
        .fault            (fault),
        .fault_code       (fault_code)
    );

    typedef struct {
        logic       rst, pres, cen, ovr, p20, p80, p100, fclr;
        logic [2:0] st;
        logic       en;
        logic [1:0] rate;
        logic       done, warn, flt;
        logic [1:0] code;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t v(input logic rst, pres, cen, ovr, p20, p80, p100, fclr,
                               input logic [2:0] st, input logic en, input logic [1:0] rate,
                               input logic done, warn, flt, input logic [1:0] code);
        vec_t r;
        r.rst = rst; r.pres = pres; r.cen = cen; r.ovr = ovr;
        r.p20 = p20; r.p80 = p80; r.p100 = p100; r.fclr = fclr;
        r.st = st; r.en = en; r.rate = rate; r.done = done;
        r.warn = warn; r.flt = flt; r.code = code;
        return r;
    endfunction

    task automatic drive(input logic rst, pres, cen, ovr, p20, p80, p100, fclr);
        reset = rst; charger_present = pres; clk_enable = cen; overcharge_alert = ovr;
        pulse_20 = p20; pulse_80 = p80; pulse_100 = p100; fault_clear = fclr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string name, input logic [2:0] st, input logic en,
                               input logic [1:0] rate, input logic done, warn, flt,
                               input logic [1:0] code);
        logic [10:0] got, exp;
        got = {state, charge_en, charge_rate, charge_done, low_batt_warn, fault, fault_code};
        exp = {st, en, rate, done, warn, flt, code};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got st=%0d en=%b rate=%b done=%b warn=%b fault=%b code=%b, expected st=%0d en=%b rate=%b done=%b warn=%b fault=%b code=%b",
                     name, state, charge_en, charge_rate, charge_done, low_batt_warn, fault, fault_code,
                     st, en, rate, done, warn, flt, code);
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        //             rst pr ce ov 20 80 100 fc   st en rate dn wn ft code
        vecs[0]  = v(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2'b00, 0, 0, 0, 2'b00);
        vecs[1]  = v(1, 1, 1, 0, 1, 0, 0, 0,   0, 0, 2'b00, 0, 0, 0, 2'b00);
        vecs[2]  = v(0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 2'b00, 0, 1, 0, 2'b00);
        vecs[3]  = v(0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 2'b00, 0, 1, 0, 2'b00);
        vecs[4]  = v(0, 1, 1, 0, 0, 0, 0, 0,   1, 1, 2'b10, 0, 0, 0, 2'b00);
        vecs[5]  = v(0, 1, 1, 0, 1, 0, 0, 0,   1, 1, 2'b10, 0, 1, 0, 2'b00);
        vecs[6]  = v(0, 1, 1, 0, 1, 1, 0, 0,   2, 1, 2'b01, 0, 1, 0, 2'b00);
        vecs[7]  = v(0, 1, 1, 0, 0, 1, 0, 0,   2, 1, 2'b01, 0, 0, 0, 2'b00);
        vecs[8]  = v(0, 1, 1, 0, 0, 0, 1, 0,   3, 0, 2'b00, 1, 0, 0, 2'b00);
        vecs[9]  = v(0, 1, 0, 0, 0, 0, 0, 0,   3, 0, 2'b00, 1, 0, 0, 2'b00);
        vecs[10] = v(0, 1, 1, 0, 0, 0, 0, 0,   2, 1, 2'b01, 0, 0, 0, 2'b00);
        vecs[11] = v(0, 1, 0, 0, 0, 0, 0, 0,   3, 0, 2'b00, 1, 0, 0, 2'b00);
        vecs[12] = v(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2'b00, 0, 0, 0, 2'b00);
        vecs[13] = v(0, 1, 1, 1, 0, 0, 0, 0,   0, 0, 2'b00, 0, 0, 0, 2'b00);
        vecs[14] = v(0, 1, 1, 0, 0, 0, 0, 0,   1, 1, 2'b10, 0, 0, 0, 2'b00);
        vecs[15] = v(0, 1, 1, 0, 0, 1, 1, 0,   3, 0, 2'b00, 1, 0, 0, 2'b00);
        vecs[16] = v(0, 1, 1, 0, 0, 0, 0, 0,   2, 1, 2'b01, 0, 0, 0, 2'b00);
        vecs[17] = v(0, 0, 1, 1, 0, 0, 0, 0,   4, 0, 2'b00, 0, 0, 1, 2'b01);
        vecs[18] = v(0, 0, 0, 0, 0, 0, 0, 1,   4, 0, 2'b00, 0, 0, 1, 2'b01);
        vecs[19] = v(0, 1, 1, 0, 0, 0, 1, 0,   4, 0, 2'b00, 0, 0, 1, 2'b01);
        vecs[20] = v(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2'b00, 0, 0, 0, 2'b00);
        vecs[21] = v(0, 1, 1, 0, 0, 0, 0, 0,   1, 1, 2'b10, 0, 0, 0, 2'b00);
        vecs[22] = v(0, 1, 1, 0, 1, 0, 0, 0,   1, 1, 2'b10, 0, 1, 0, 2'b00);
        vecs[23] = v(1, 1, 1, 0, 0, 0, 0, 0,   0, 0, 2'b00, 0, 0, 0, 2'b00);

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rst, vecs[i].pres, vecs[i].cen, vecs[i].ovr,
                  vecs[i].p20, vecs[i].p80, vecs[i].p100, vecs[i].fclr);
            tick();
            expect_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].rate,
                        vecs[i].done, vecs[i].warn, vecs[i].flt, vecs[i].code);
        end

        // Fault hold: clear only accepted once 100 cycles have elapsed in FAULT
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0, 0, 0, 0); tick();
        expect_outs("hold_fast", 1, 1, 2'b10, 0, 0, 0, 2'b00);
        drive(0, 1, 1, 1, 0, 0, 0, 0); tick();
        expect_outs("hold_enter", 4, 0, 2'b00, 0, 0, 1, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (50) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        expect_outs("hold_clear50", 4, 0, 2'b00, 0, 0, 1, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (48) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        expect_outs("hold_clear99", 4, 0, 2'b00, 0, 0, 1, 2'b01);
        drive(0, 0, 0, 1, 0, 0, 0, 1); tick();
        expect_outs("hold_clear_ovr", 4, 0, 2'b00, 0, 0, 1, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) tick();
        expect_outs("hold_no_memory", 4, 0, 2'b00, 0, 0, 1, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        expect_outs("hold_clear_ok", 0, 0, 2'b00, 0, 0, 0, 2'b00);

        // FAST timeout at 20 cycles
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0, 0, 0, 0); tick();
        repeat (19) tick();
        expect_outs("tmo_cycle19", 1, 1, 2'b10, 0, 0, 0, 2'b00);
        tick();
`ifdef CHARGE_TIMEOUT_EN
        expect_outs("tmo_cycle20", 4, 0, 2'b00, 0, 0, 1, 2'b10);
        tick();
        expect_outs("tmo_cycle21", 4, 0, 2'b00, 0, 0, 1, 2'b10);
`else
        expect_outs("tmo_cycle20", 1, 1, 2'b10, 0, 0, 0, 2'b00);
        tick();
        expect_outs("tmo_cycle21", 1, 1, 2'b10, 0, 0, 0, 2'b00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/charge_controller.md
CHARGE_CONTROLLER -- requirements
Module: charge_controller

Interface
REQ-001 The parameter list SHALL be exactly: FAST_TIMEOUT, 16'd50000, maximum cycles in FAST.
REQ-002 The next parameter SHALL be TOPOFF_TIMEOUT, 16'd10000, maximum cycles in TOPOFF.
REQ-003 The last parameter SHALL be FAULT_HOLD, 8'd100, minimum cycles in FAULT before clear is accepted.
REQ-004 Port clk SHALL be: input, 1 bit, the single system clock; all logic on its rising edge.
REQ-005 Port reset SHALL be: input, 1 bit, synchronous active-high reset.
REQ-006 Port charger_present SHALL be: input, 1 bit, external charger attached.
REQ-007 Ports pulse_20, pulse_80 and pulse_100 SHALL each be: input, 1 bit, one-cycle level pulses from the battery health monitor.
REQ-008 Ports clk_enable and overcharge_alert SHALL each be: input, 1 bit, the monitor's charge-permit and overcharge levels.
REQ-009 Port fault_clear SHALL be: input, 1 bit, host request to leave FAULT.
REQ-010 Port charge_en SHALL be: output, 1 bit, charger switch on.
REQ-011 Port charge_rate SHALL be: output, 2 bits; 00 off, 01 top-off, 10 fast; 11 never driven.
REQ-012 Port state SHALL be: output, 3 bits, current FSM state.
REQ-013 Ports charge_done, low_batt_warn and fault SHALL each be: output, 1 bit, status flags.
REQ-014 Port fault_code SHALL be: output, 2 bits; 00 none, 01 overcharge, 10 timeout.

Function
REQ-015 The FSM states SHALL be IDLE=0, FAST=1, TOPOFF=2, FULL=3, FAULT=4, and all outputs SHALL be registered and reflect the state entered at the same edge.
REQ-016 IDLE SHALL go to FAST when charger_present && clk_enable && !overcharge_alert.
REQ-017 FAST SHALL go to FULL on pulse_100, to TOPOFF on pulse_80, and otherwise remain.
REQ-018 TOPOFF SHALL go to FULL on pulse_100 or clk_enable==0.
REQ-019 FULL SHALL go to TOPOFF when clk_enable==1 && charger_present (recharge).
REQ-020 From FAST, TOPOFF and FULL, transition priority SHALL be: overcharge_alert -> FAULT(01); !charger_present -> IDLE; timer expiry -> FAULT(10); pulse_100; pulse_80.
REQ-021 FAULT SHALL go to IDLE only when fault_clear && !overcharge_alert && the hold counter has reached FAULT_HOLD; an early fault_clear SHALL be ignored and not remembered.
REQ-022 charge_en SHALL be 1 exactly in FAST and TOPOFF, with charge_rate 10 and 01 respectively, and 00 elsewhere.
REQ-023 charge_done SHALL be 1 exactly in FULL.
REQ-024 fault SHALL be 1 exactly in FAULT; fault_code SHALL hold its cause until FAULT exits, then return to 00.
REQ-025 low_batt_warn SHALL set on pulse_20 in any state and clear on entry to FAST or on pulse_80; set SHALL win over clear in the same cycle.
REQ-026 The fault hold counter SHALL be 8 bits, cleared on FAULT entry, and saturate at FAULT_HOLD.
REQ-027 Simultaneous pulse_80 and pulse_100 in FAST SHALL go to FULL.
REQ-028 Pulses arriving in a state with no matching transition SHALL be dropped.

Reset
REQ-029 Reset SHALL take priority over all inputs and force state IDLE, charge_en 0, charge_rate 00, charge_done 0, low_batt_warn 0, fault 0, fault_code 00, all counters 0.
REQ-030 Reset asserted mid-charge SHALL deassert charge_en on the same edge.

Configuration
REQ-031 With CHARGE_TIMEOUT_EN defined, a 16-bit safety timer SHALL clear on entry to FAST or TOPOFF, count each cycle in that state, and, on reaching FAST_TIMEOUT or TOPOFF_TIMEOUT respectively, force FAULT with code 10.
REQ-032 Without CHARGE_TIMEOUT_EN, the timer SHALL be absent, no timeout transition SHALL exist, and fault_code 10 SHALL never occur.

Structure
REQ-033 A shared package bms_pkg SHALL hold the state enum, charge_rate encodings and fault_code encodings.
REQ-034 The safety timer SHALL be the sub-module charge_safety_timer (inputs: restart, enable, limit; output: expired), instantiated only under CHARGE_TIMEOUT_EN.

Verification
REQ-035 Bench SHALL cover: reset, then charger_present=1, clk_enable=1 -> state FAST, charge_rate 10 one cycle later; pulse_80 -> TOPOFF, rate 01; pulse_100 -> FULL, charge_done 1, charge_en 0.
REQ-036 Bench SHALL cover: in TOPOFF, overcharge_alert=1 together with charger_present=0 -> FAULT with fault_code 01, not IDLE.
REQ-037 Bench SHALL cover: FAULT with fault_clear pulsed at cycle 50 -> remains FAULT; fault_clear at cycle 100 with overcharge_alert=0 -> IDLE, fault_code 00.
REQ-038 Bench SHALL cover: CHARGE_TIMEOUT_EN defined, FAST_TIMEOUT=16'd20, no pulses -> FAULT code 10 after 20 FAST cycles; the same stimulus without the macro -> stays FAST.
REQ-039 Bench SHALL cover: pulse_20 in IDLE -> low_batt_warn 1; entry to FAST -> low_batt_warn 0; reset asserted during FAST -> all outputs at reset values the next cycle.
